seg_mux_drv: RTL

Parametrised, time-multiplexed 7-segment display driver: scans DIGITS common-drain digits with programmable dwell and inter-digit blanking. Data is double-buffered and committed only at frame boundaries, so a display frame never mixes old and new values. Per-digit decimal points and configurable output polarities are supported. It sits between a CPU-visible value register and the board's digit drains and segment lines, and supersedes the fixed 8-digit/32-bit scanner.

---
 rtl/seg_mux_drv.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seg_mux_drv.sv
// Time-multiplexed 7-segment scanner with frame-synchronous double buffering.
// Optional leading-zero blanking: define SEGMUX_LZB_EN.
module seg_mux_drv #(
   parameter int DIGITS    = 8,
   parameter int DWELL     = 1024,
   parameter int BLANK     = 16,
   parameter bit DRAIN_ACT = 1'b1,
   parameter bit SEG_ACT   = 1'b1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  OE,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dots,
   output logic [DIGITS-1:0]     drains,
   output logic [7:0]            leds,
   output logic                  frame
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIGITS-1:0] DRN_OFF = {DIGITS{~DRAIN_ACT}};
   localparam logic [7:0]        SEG_OFF = {8{~SEG_ACT}};

   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [4*DIGITS-1:0]    stg_data, dsp_data;
   logic [DIGITS-1:0]      stg_dots, dsp_dots;

   logic [3:0]             nib;
   logic                   dp;
   logic                   lz_sel;
   logic [6:0]             seg_on;
   logic [DIGITS-1:0]      onehot;
   logic                   slot_end, frame_start;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
         4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
         4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
         4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
      endcase
   endfunction

`ifdef SEGMUX_LZB_EN
   // lz[d]: nibble d and every nibble above it are zero; digit 0 always shown
   logic [DIGITS-1:0] lz;
   assign lz[0] = 1'b0;
   for (genvar d = 1; d < DIGITS; d++) begin : g_lz
      assign lz[d] = (dsp_data[4*DIGITS-1:4*d] == '0);
   end
`endif

   always_comb begin
      nib    = 4'h0;
      dp     = 1'b0;
      lz_sel = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (idx == IW'(d)) begin
            nib = dsp_data[4*d +: 4];
            dp  = dsp_dots[d];
`ifdef SEGMUX_LZB_EN
            lz_sel = lz[d];
`endif
         end
      end
      seg_on = lz_sel ? 7'h00 : font(nib);
   end

   assign onehot      = DIGITS'(1) << idx;
   assign slot_end    = (cnt == CW'(DWELL - 1));
   assign frame_start = (cnt == '0) && (idx == '0);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= '0;
         idx      <= '0;
         stg_data <= '0;
         stg_dots <= '0;
         dsp_data <= '0;
         dsp_dots <= '0;
         drains   <= DRN_OFF;
         leds     <= SEG_OFF;
         frame    <= 1'b0;
      end else begin
         if (LOAD) begin
            stg_data <= data;
            stg_dots <= dots;
         end
         if (OE) begin
            frame <= frame_start;
            // commit uses the pre-edge staging value, so a same-edge LOAD waits a frame
            if (frame_start) begin
               dsp_data <= stg_data;
               dsp_dots <= stg_dots;
            end
            if (slot_end) begin
               cnt <= '0;
               idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
            if (cnt < CW'(BLANK)) begin
               drains <= DRN_OFF;
               leds   <= SEG_OFF;
            end else begin
               drains <= onehot ^ DRN_OFF;
               leds   <= {dp, seg_on} ^ SEG_OFF;
            end
         end else begin
            cnt    <= '0;
            idx    <= '0;
            drains <= DRN_OFF;
            leds   <= SEG_OFF;
            frame  <= 1'b0;
         end
      end
   end
endmodule
